// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: walks a heap-indexed trie on dot/dash pulses and commits
// one registered ASCII letter with a single-cycle letter_valid strobe.
module morse_letter_decoder #(
  parameter int unsigned MAX_SYMBOLS  = 5,
  parameter int unsigned IDLE_TIMEOUT = 0,
  parameter int unsigned TO_WIDTH     = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_pulse,
  input  logic       dash_pulse,
  input  logic       done_pulse,
  input  logic       clear,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic [2:0] symbol_count,
  output logic       busy
);

  localparam int unsigned NodeW = MAX_SYMBOLS + 1;
  localparam logic [NodeW-1:0]    RootNode  = NodeW'(1);
  localparam logic [2:0]          MaxCount  = 3'(MAX_SYMBOLS);
  localparam logic [TO_WIDTH-1:0] ToLast    = TO_WIDTH'(IDLE_TIMEOUT - 1);
  localparam bit                  TimeoutEn = (IDLE_TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

  state_e              state_q, state_d;
  logic [NodeW-1:0]    node_q, node_d;
  logic [2:0]          count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [TO_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]          letter_q, letter_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  logic                one_symbol;
  logic                timed_out;
  logic [NodeW-1:0]    node_next;
  logic [TO_WIDTH-1:0] timer_inc;
  logic [7:0]          lookup_char;

  // Returns 8'h00 for nodes that do not terminate a known code.
  function automatic logic [7:0] node_to_ascii(input logic [NodeW-1:0] n);
    logic [7:0] c;
    case (32'(n))
      2:  c = "E";
      3:  c = "T";
      4:  c = "I";
      5:  c = "A";
      6:  c = "N";
      7:  c = "M";
      8:  c = "S";
      9:  c = "U";
      10: c = "R";
      11: c = "W";
      12: c = "D";
      13: c = "K";
      14: c = "G";
      15: c = "O";
      16: c = "H";
      17: c = "V";
      18: c = "F";
      20: c = "L";
      22: c = "P";
      23: c = "J";
      24: c = "B";
      25: c = "X";
      26: c = "C";
      27: c = "Y";
      28: c = "Z";
      29: c = "Q";
      32: c = "5";
      33: c = "4";
      35: c = "3";
      39: c = "2";
      47: c = "1";
      48: c = "6";
      56: c = "7";
      60: c = "8";
      62: c = "9";
      63: c = "0";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  assign one_symbol  = dot_pulse ^ dash_pulse;
  assign node_next   = {node_q[NodeW-2:0], dash_pulse};
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign timed_out   = TimeoutEn && (timer_q == ToLast);
  assign lookup_char = node_to_ascii(node_q);

  always_comb begin
    state_d  = state_q;
    node_d   = node_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    timer_d  = timer_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!clear) begin
          if (done_pulse) begin
            state_d  = StEmit;
            letter_d = 8'h20;
            valid_d  = 1'b1;
          end else if (one_symbol) begin
            state_d = StCollect;
            node_d  = node_next;
            count_d = 3'd1;
            timer_d = '0;
          end
        end
      end

      StCollect: begin
        if (clear) begin
          state_d = StIdle;
          node_d  = RootNode;
          count_d = '0;
          ovf_d   = 1'b0;
          timer_d = '0;
        end else if (done_pulse || timed_out) begin
          // Any symbol arriving with the commit is dropped.
          state_d = StEmit;
          valid_d = 1'b1;
          if (ovf_q || (lookup_char == 8'h00)) begin
            letter_d = 8'h3F;
            error_d  = 1'b1;
          end else begin
            letter_d = lookup_char;
          end
          node_d  = RootNode;
          count_d = '0;
          ovf_d   = 1'b0;
          timer_d = '0;
        end else if (one_symbol && (count_q < MaxCount)) begin
          node_d  = node_next;
          count_d = count_q + 3'd1;
          timer_d = '0;
        end else begin
          // Overflowing symbols are not accepted, so they do not restart the timeout.
          if (one_symbol) begin
            ovf_d = 1'b1;
          end
          timer_d = timer_inc;
        end
      end

      StEmit: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      node_q   <= RootNode;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
      letter_q <= 8'h20;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      node_q   <= node_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign error        = error_q;
  assign symbol_count = count_q;
  assign busy         = (state_q == StCollect);

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Bench for morse_letter_decoder: a string-keyed Morse table model checked every cycle,
// plus directed sequences with literal expected letters.
module tb_morse_letter_decoder;

  localparam int unsigned Timeout = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dot_pulse = 1'b0;
  logic       dash_pulse = 1'b0;
  logic       done_pulse = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] letter;
  logic       letter_valid;
  logic       error;
  logic [2:0] symbol_count;
  logic       busy;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  morse_letter_decoder #(
    .MAX_SYMBOLS (5),
    .IDLE_TIMEOUT(Timeout),
    .TO_WIDTH    (27)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dot_pulse   (dot_pulse),
    .dash_pulse  (dash_pulse),
    .done_pulse  (done_pulse),
    .clear       (clear),
    .letter      (letter),
    .letter_valid(letter_valid),
    .error       (error),
    .symbol_count(symbol_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Model state: the code is kept as a string of '.' and '-'.
  byte unsigned morse [string];
  string        m_code = "";
  bit           m_coll = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_emit = 1'b0;
  bit           m_err = 1'b0;
  int           m_idle = 0;
  byte unsigned m_letter = 8'h20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit was_emit;
    was_emit = m_emit;
    m_emit   = 1'b0;
    m_err    = 1'b0;
    if (!reset) begin
      m_code   = "";
      m_coll   = 1'b0;
      m_ovf    = 1'b0;
      m_idle   = 0;
      m_letter = 8'h20;
    end else if (was_emit) begin
      // inputs ignored during the strobe cycle
    end else if (clear) begin
      m_code = "";
      m_coll = 1'b0;
      m_ovf  = 1'b0;
      m_idle = 0;
    end else if (done_pulse || (m_coll && m_idle == int'(Timeout) - 1)) begin
      m_emit = 1'b1;
      if (!m_coll) begin
        m_letter = 8'h20;
      end else if (m_ovf || !morse.exists(m_code)) begin
        m_letter = 8'h3F;
        m_err    = 1'b1;
      end else begin
        m_letter = morse[m_code];
      end
      m_code = "";
      m_coll = 1'b0;
      m_ovf  = 1'b0;
      m_idle = 0;
    end else if (dot_pulse != dash_pulse) begin
      if (m_code.len() < 5) begin
        if (dash_pulse) m_code = {m_code, "-"};
        else m_code = {m_code, "."};
        m_coll = 1'b1;
        m_idle = 0;
      end else begin
        m_ovf = 1'b1;
        m_idle++;
      end
    end else if (m_coll) begin
      m_idle++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model valid", letter_valid, m_emit);
      check("model letter", letter, m_letter);
      check("model error", error, m_err);
      check("model busy", busy, m_coll);
      if (!m_emit) check("model count", symbol_count, m_code.len());
    end
  end

  task automatic step(input bit d, input bit s, input bit dn, input bit cl);
    dot_pulse  = d;
    dash_pulse = s;
    done_pulse = dn;
    clear      = cl;
    @(negedge clk);
    dot_pulse  = 1'b0;
    dash_pulse = 1'b0;
    done_pulse = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic expect_strobe(input string name, input logic [7:0] exp_l, input bit exp_e);
    check({name, " strobe"}, letter_valid, 1);
    check({name, " letter"}, letter, exp_l);
    check({name, " error"}, error, exp_e);
    step(0, 0, 0, 0);
    check({name, " strobe width"}, letter_valid, 0);
  endtask

  task automatic send(input string code, input logic [7:0] exp_l, input bit exp_e);
    for (int i = 0; i < code.len(); i++) step(code[i] == ".", code[i] == "-", 1'b0, 1'b0);
    step(0, 0, 1, 0);
    expect_strobe({"code '", code, "'"}, exp_l, exp_e);
  endtask

  string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..", ".----", "..---", "...--",
                        "....-", ".....", "-....", "--...", "---..", "----.", "-----"};
  string glyphs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ1234567890";

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    foreach (codes[i]) morse[codes[i]] = glyphs[i];

    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("reset letter", letter, 8'h20);
    check("reset valid", letter_valid, 0);
    check("reset error", error, 0);
    check("reset busy", busy, 0);
    check("reset count", symbol_count, 0);
    reset = 1'b1;
    @(negedge clk);

    send(".-", 8'h41, 0);
    send("---", 8'h4F, 0);
    send(".----", 8'h31, 0);

    repeat (6) step(1, 0, 0, 0);
    check("overflow count", symbol_count, 5);
    step(0, 0, 1, 0);
    expect_strobe("overflow", 8'h3F, 1);

    send("..--", 8'h3F, 1);
    send("", 8'h20, 0);

    // done with a concurrent dash commits the dot only
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    expect_strobe("collision", 8'h45, 0);

    step(1, 1, 0, 0);
    check("dot+dash idle busy", busy, 0);
    check("dot+dash idle count", symbol_count, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("dot+dash collect count", symbol_count, 1);
    step(0, 0, 1, 0);
    expect_strobe("dot+dash", 8'h45, 0);

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("clear valid", letter_valid, 0);
    check("clear busy", busy, 0);
    check("clear count", symbol_count, 0);
    step(0, 0, 0, 0);
    check("clear no strobe", letter_valid, 0);
    check("clear letter held", letter, 8'h45);

    // a dot during the strobe cycle is ignored
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("emit-ignore letter", letter, 8'h54);
    step(1, 0, 0, 0);
    check("emit-ignore busy", busy, 0);
    check("emit-ignore count", symbol_count, 0);
    step(0, 0, 1, 0);
    expect_strobe("emit-ignore space", 8'h20, 0);

    step(0, 1, 0, 0);
    n = 0;
    while (!letter_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout latency", n, 16);
    expect_strobe("timeout", 8'h54, 0);

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset count", symbol_count, 0);
    check("async reset valid", letter_valid, 0);
    check("async reset letter", letter, 8'h20);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0);
    check("post reset no strobe", letter_valid, 0);
    send(".", 8'h45, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
